gen_fifo_ram2p: RTL and testbench
=================================

Name: gen_fifo_ram2p

Overview:
- Parametrised synchronous FIFO. Storage is an internal two-port RAM: one write port, one read port, 1-cycle registered read.
- Successor to the fixed 8-deep x 256-bit two-port RAM wrappers. Width and depth are generic.
- Adds valid/ready handshakes, first-word-fall-through output, fill level, flags and synchronous flush.
- Sits between DMA descriptor/data producers and consumers in the clockCore domain.

Parameters:
- WIDTH, 256, data width in bits (1..1024).
- DEPTH, 8, RAM entries; power of two, 4..4096.
- AFULL_LVL, DEPTH-2, level at or above which almostFull asserts.

Ports:
- clockCore  input  1  core clock; all logic on rising edge.
- resetCoreN  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all contents.
- writeValid  input  1  producer offers writeData.
- writeReady  output  1  FIFO can accept; registered.
- writeData  input  WIDTH  write payload.
- readValid  output  1  readData holds the head entry; registered.
- readReady  input  1  consumer takes head this cycle.
- readData  output  WIDTH  head entry; registered.
- fillLevel  output  $clog2(DEPTH+1)  entries held (RAM + in-flight + output stage).
- almostFull  output  1  fillLevel >= AFULL_LVL; registered.
- empty  output  1  fillLevel == 0; registered.

Behaviour:
- Reset is asynchronous, active-low. In reset: writeReady=0, readValid=0, readData=0, fillLevel=0, almostFull=0, empty=1, all pointers 0.
- writeReady rises at the first clockCore edge after resetCoreN deasserts.
- Write is accepted on an edge where writeValid && writeReady. The data goes to RAM[wrPtr] and wrPtr increments, wrapping mod DEPTH.
- Read is accepted on an edge where readValid && readReady. The head is popped. readData/readValid update at the same edge to the next entry, or readValid=0 if none.
- readData is stable while readValid && !readReady.
- Total capacity is DEPTH. writeReady_next = (fillLevel_next < DEPTH). No write is ever accepted when full; writeValid while full is ignored.
- Output stage is a 2-entry skid buffer.
  - A RAM read is issued when the RAM is non-empty and (skid occupancy + reads in flight) < 2.
  - Read data lands in the skid 1 cycle after issue.
- Latency:
  - Write accepted at edge T into an empty FIFO -> readValid=1 after edge T+2.
  - Sustained 1 write + 1 read per cycle with no bubbles once primed.
- Simultaneous push and pop: fillLevel unchanged. When full, a pop and push on the same edge are both accepted only if writeReady was already 1. writeReady is registered, so there is no same-cycle pop-to-push bypass.
- Read-during-write to the same RAM address cannot occur, because reads only target written entries. The RAM model need not forward.
- flush (sampled high at edge T):
  - Pointers, skid and in-flight reads are cleared; fillLevel=0, readValid=0, empty=1.
  - writeReady=1 after T. A write or read presented at edge T is discarded.
  - flush has priority over all other events.
- Reset asserted mid-operation: all state clears immediately. Contents are lost; RAM array contents are not cleared.
- Pointers are $clog2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
- fillLevel = write count minus pop count, saturating logic forbidden; it is exact by construction.

Optional Feature:
- Macro: GEN_FIFO_ERR_EN.
- When defined, adds output errSticky (2 bits):
  - bit0 = overflow attempt: writeValid while !writeReady, outside reset and flush.
  - bit1 = underflow attempt: readReady while !readValid, only counted after the first ever pop.
  - Bits are set on the edge and cleared only by reset or flush.
- When undefined, the port and logic are absent. All other behaviour is identical.

Decomposition:
- Package gen_fifo_pkg holds:
  - a clog2-based width helper;
  - constant SKID_DEPTH=2;
  - skid-state encoding constants SK_EMPTY, SK_ONE, SK_TWO.
- Sub-module gen_ram2p_param (WIDTH, DEPTH) holds the storage.
  - Ports: clockCore, enableRead, addressRead, enableWrite, addressWrite, writeData, readData.
  - 1-cycle registered read; no reset on the array.

Test Plan:
- Reset then idle: writeReady=0 during reset, 1 one cycle after release. empty=1, fillLevel=0, readValid=0.
- DEPTH=8, WIDTH=256, write 0x01..0x08 back-to-back with readReady=0:
  - writeReady drops after the 8th accept; fillLevel=8.
  - almostFull rises when fillLevel reaches 6.
  - A 9th write of 0xFF is not accepted.
- Continuing from that full state, readReady=1: data pops 0x01..0x08 in order, one per cycle, no bubbles. empty=1 after the last pop.
- Single write 0xA5 at edge T into an empty FIFO -> readValid=1, readData=0xA5 after edge T+2.
- Streaming 100 words with writeValid=1 and random readReady (50%): output sequence equals input sequence, and fillLevel never exceeds 8.
- With 5 entries held, pulse flush together with writeValid (0x77) and readReady: fillLevel=0, readValid=0, and a later read never returns 0x77 or the old data.
- GEN_FIFO_ERR_EN defined: write while full -> errSticky=2'b01, held until flush; flush -> 2'b00.

Source files
------------

// File: rtl/gen_fifo_pkg.sv
// gen_fifo_pkg: shared constants and width helper for gen_fifo_ram2p.
// Optional error flags are enabled by defining GEN_FIFO_ERR_EN.
package gen_fifo_pkg;

  localparam int SKID_DEPTH = 2;

  localparam logic [1:0] SK_EMPTY = 2'd0;
  localparam logic [1:0] SK_ONE   = 2'd1;
  localparam logic [1:0] SK_TWO   = 2'd2;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/gen_ram2p_param.sv
// gen_ram2p_param: two-port RAM, one write port, one read port,
// 1-cycle registered read, no reset on the array.
module gen_ram2p_param #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clockCore,
  input  logic             enableRead,
  input  logic [AW-1:0]    addressRead,
  input  logic             enableWrite,
  input  logic [AW-1:0]    addressWrite,
  input  logic [WIDTH-1:0] writeData,
  output logic [WIDTH-1:0] readData
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_q;

  always_ff @(posedge clockCore) begin
    if (enableWrite) mem_q[addressWrite] <= writeData;
    if (enableRead)  rd_q <= mem_q[addressRead];
  end

  assign readData = rd_q;

endmodule

// File: rtl/gen_fifo_ram2p.sv
// gen_fifo_ram2p: FWFT FIFO over a two-port RAM with a 2-entry skid output.
// Define GEN_FIFO_ERR_EN to add the errSticky overflow/underflow flags.
module gen_fifo_ram2p
  import gen_fifo_pkg::*;
#(
  parameter int WIDTH     = 256,
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = DEPTH - 2,
  parameter int LW        = $clog2(DEPTH + 1)
) (
  input  logic             clockCore,
  input  logic             resetCoreN,
  input  logic             flush,
  input  logic             writeValid,
  output logic             writeReady,
  input  logic [WIDTH-1:0] writeData,
  output logic             readValid,
  input  logic             readReady,
  output logic [WIDTH-1:0] readData,
  output logic [LW-1:0]    fillLevel,
  output logic             almostFull,
  output logic             empty
`ifdef GEN_FIFO_ERR_EN
  ,
  output logic [1:0]       errSticky
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             infl_q, infl_d;
  logic [1:0]       skid_q, skid_d, skid_n;
  logic [WIDTH-1:0] sk0_q, sk0_d, sk1_q, sk1_d;
  logic             rvalid_q, rvalid_d, wrdy_q, wrdy_d;
  logic             afull_q, afull_d, empty_q, empty_d;
  logic [LW-1:0]    fill_q, fill_d;
  logic [WIDTH-1:0] ram_rdata;
  logic [2:0]       occ;
  logic             push, pop, ram_ne, issue;

  assign push   = writeValid & wrdy_q;
  assign pop    = rvalid_q & readReady;
  assign ram_ne = wr_ptr_q != rd_ptr_q;
  assign occ    = {1'b0, skid_q} + {2'b0, infl_q};
  // Counting this cycle's pop keeps the skid refilling with no bubbles.
  assign issue  = ram_ne && ((occ - {2'b0, pop}) < 3'(SKID_DEPTH));

  gen_ram2p_param #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clockCore   (clockCore),
    .enableRead  (issue & ~flush),
    .addressRead (rd_ptr_q[AW-1:0]),
    .enableWrite (push & ~flush),
    .addressWrite(wr_ptr_q[AW-1:0]),
    .writeData   (writeData),
    .readData    (ram_rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    infl_d   = infl_q;
    skid_d   = skid_q;
    skid_n   = skid_q;
    sk0_d    = sk0_q;
    sk1_d    = sk1_q;
    rvalid_d = rvalid_q;
    fill_d   = fill_q;
    wrdy_d   = wrdy_q;
    afull_d  = afull_q;
    empty_d  = empty_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      infl_d   = 1'b0;
      skid_d   = SK_EMPTY;
      rvalid_d = 1'b0;
      fill_d   = '0;
      wrdy_d   = 1'b1;
      afull_d  = 1'b0;
      empty_d  = 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(issue);
      infl_d   = issue;
      if (pop) begin
        sk0_d  = sk1_q;
        skid_n = skid_n - 2'd1;
      end
      if (infl_q) begin
        if (skid_n == SK_EMPTY) sk0_d = ram_rdata;
        else                    sk1_d = ram_rdata;
        skid_n = skid_n + 2'd1;
      end
      skid_d   = skid_n;
      rvalid_d = skid_n != SK_EMPTY;
      fill_d   = fill_q + LW'(push) - LW'(pop);
      wrdy_d   = fill_d < LW'(DEPTH);
      afull_d  = fill_d >= LW'(AFULL_LVL);
      empty_d  = fill_d == '0;
    end
  end

  always_ff @(posedge clockCore or negedge resetCoreN) begin
    if (!resetCoreN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      infl_q   <= 1'b0;
      skid_q   <= SK_EMPTY;
      sk0_q    <= '0;
      sk1_q    <= '0;
      rvalid_q <= 1'b0;
      fill_q   <= '0;
      wrdy_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      infl_q   <= infl_d;
      skid_q   <= skid_d;
      sk0_q    <= sk0_d;
      sk1_q    <= sk1_d;
      rvalid_q <= rvalid_d;
      fill_q   <= fill_d;
      wrdy_q   <= wrdy_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
    end
  end

  assign writeReady = wrdy_q;
  assign readValid  = rvalid_q;
  assign readData   = sk0_q;
  assign fillLevel  = fill_q;
  assign almostFull = afull_q;
  assign empty      = empty_q;

`ifdef GEN_FIFO_ERR_EN
  logic [1:0] err_q, err_d;
  logic       popped_q, popped_d;

  always_comb begin
    err_d    = err_q;
    popped_d = popped_q | (pop & ~flush);
    if (flush) begin
      err_d = 2'b00;
    end else begin
      if (writeValid && !wrdy_q)              err_d[0] = 1'b1;
      if (readReady && !rvalid_q && popped_q) err_d[1] = 1'b1;
    end
  end

  always_ff @(posedge clockCore or negedge resetCoreN) begin
    if (!resetCoreN) begin
      err_q    <= 2'b00;
      popped_q <= 1'b0;
    end else begin
      err_q    <= err_d;
      popped_q <= popped_d;
    end
  end

  assign errSticky = err_q;
`endif

endmodule

// File: tb/tb_gen_fifo_ram2p.sv
// tb_gen_fifo_ram2p: table vectors plus scoreboard for gen_fifo_ram2p.
// Error-flag checks are included when GEN_FIFO_ERR_EN is defined.
module tb_gen_fifo_ram2p;

  localparam int W = 256;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         wv = 1'b0;
  logic         rr = 1'b0;
  logic [W-1:0] wd = '0;
  logic         writeReady, readValid, almostFull, empty;
  logic [W-1:0] readData;
  logic [3:0]   fillLevel;
`ifdef GEN_FIFO_ERR_EN
  logic [1:0]   err;
`endif

  always #5 clk = ~clk;

  gen_fifo_ram2p #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clockCore (clk),
    .resetCoreN(rst_n),
    .flush     (flush),
    .writeValid(wv),
    .writeReady(writeReady),
    .writeData (wd),
    .readValid (readValid),
    .readReady (rr),
    .readData  (readData),
    .fillLevel (fillLevel),
    .almostFull(almostFull),
    .empty     (empty)
`ifdef GEN_FIFO_ERR_EN
    ,
    .errSticky (err)
`endif
  );

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         r;
    int           fill;
    logic         wrdy;
    logic         afull;
    logic         emp;
    logic         rv;
  } vec_t;

  int           total = 0;
  int           bad = 0;
  logic [W-1:0] sb[$];
  vec_t         tbl[9];

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One clock: drive, account handshakes in the scoreboard, settle.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic r);
    wv = v;
    wd = d;
    rr = r;
    if (v && writeReady) sb.push_back(d);
    if (readValid && r) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_pop: got %0h want nothing", readData);
      end else begin
        logic [W-1:0] e;
        e = sb.pop_front();
        if (readData !== e) begin
          bad++;
          $display("FAIL rdata: got %0h want %0h", readData, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 9; i++) begin
      tbl[i].v     = 1'b1;
      tbl[i].d     = (i < 8) ? W'(i + 1) : W'(8'hFF);
      tbl[i].r     = 1'b0;
      tbl[i].fill  = (i < 8) ? i + 1 : 8;
      tbl[i].wrdy  = (i + 1) < 8;
      tbl[i].afull = tbl[i].fill >= 6;
      tbl[i].emp   = 1'b0;
      tbl[i].rv    = i >= 2;
    end

    // Reset and release
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wready", W'(writeReady), 0);
    chk("rst_empty", W'(empty), 1);
    chk("rst_fill", W'(fillLevel), 0);
    chk("rst_rvalid", W'(readValid), 0);
    chk("rst_rdata", readData, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("pre_edge_wready", W'(writeReady), 0);
    @(posedge clk);
    #1;
    chk("post_rel_wready", W'(writeReady), 1);

    // Fill to full, 9th write refused
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("fill[%0d]", i), W'(fillLevel), W'(tbl[i].fill));
      chk($sformatf("wrdy[%0d]", i), W'(writeReady), W'(tbl[i].wrdy));
      chk($sformatf("afull[%0d]", i), W'(almostFull), W'(tbl[i].afull));
      chk($sformatf("empty[%0d]", i), W'(empty), W'(tbl[i].emp));
      chk($sformatf("rv[%0d]", i), W'(readValid), W'(tbl[i].rv));
    end

    // Drain with no bubbles
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_rv[%0d]", i), W'(readValid), 1);
      cyc(1'b0, '0, 1'b1);
    end
    chk("drain_empty", W'(empty), 1);
    chk("drain_fill", W'(fillLevel), 0);
    chk("drain_rv_end", W'(readValid), 0);
    chk("drain_sb", W'(sb.size()), 0);

    // Single write latency
    cyc(1'b1, W'(8'hA5), 1'b0);
    chk("lat_t0", W'(readValid), 0);
    cyc(1'b0, '0, 1'b0);
    chk("lat_t1", W'(readValid), 0);
    cyc(1'b0, '0, 1'b0);
    chk("lat_t2", W'(readValid), 1);
    chk("lat_data", readData, W'(8'hA5));
    cyc(1'b0, '0, 1'b1);

    // Streaming with random consumer
    begin
      int n, guard;
      n = 0;
      guard = 0;
      while (n < 100 && guard < 2000) begin
        if (writeReady) n++;
        cyc(1'b1, W'(32'h1000 + n), 1'($urandom_range(1)));
        chk("stream_fill_le8", W'(fillLevel <= 4'd8), 1);
        guard++;
      end
      chk("stream_sent", W'(n), 100);
      guard = 0;
      while (sb.size() != 0 && guard < 50) begin
        cyc(1'b0, '0, 1'b1);
        guard++;
      end
      chk("stream_sb_drained", W'(sb.size()), 0);
      chk("stream_empty", W'(empty), 1);
    end

    // Flush with 5 held, concurrent write/read discarded
    for (int i = 0; i < 5; i++) cyc(1'b1, W'(8'h10 + i), 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b0);
    chk("pre_flush_fill", W'(fillLevel), 5);
    flush = 1'b1;
    wv = 1'b1;
    wd = W'(8'h77);
    rr = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wv = 1'b0;
    rr = 1'b0;
    sb.delete();
    chk("flush_fill", W'(fillLevel), 0);
    chk("flush_rv", W'(readValid), 0);
    chk("flush_empty", W'(empty), 1);
    chk("flush_wrdy", W'(writeReady), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b0);
      chk($sformatf("post_flush_rv[%0d]", i), W'(readValid), 0);
    end
    cyc(1'b1, W'(8'h3C), 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("post_flush_data", readData, W'(8'h3C));
    cyc(1'b0, '0, 1'b1);
    chk("post_flush_empty", W'(empty), 1);

`ifdef GEN_FIFO_ERR_EN
    chk("err_clean", W'(err), 0);
    for (int i = 0; i < 8; i++) cyc(1'b1, W'(i), 1'b0);
    cyc(1'b1, W'(8'hEE), 1'b0);
    chk("err_ovf", W'(err), 1);
    cyc(1'b0, '0, 1'b0);
    chk("err_hold", W'(err), 1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    sb.delete();
    chk("err_flush", W'(err), 0);
`endif

    // Async reset mid-operation
    cyc(1'b1, W'(8'h55), 1'b0);
    cyc(1'b1, W'(8'h56), 1'b0);
    cyc(1'b0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_fill", W'(fillLevel), 0);
    chk("async_rv", W'(readValid), 0);
    chk("async_wrdy", W'(writeReady), 0);
    chk("async_empty", W'(empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
